// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequencing controller for an odd-sum iterative integer square-root datapath
// Ports: clk_i/rst_ni clock and async active-low reset; in_valid_i/in_ready_o/in_dt_i operand handshake;
// out_valid_o/out_ready_i/out_root_o/out_err_o result handshake; dp_busy_o/dp_dt_o drive the datapath;
// dp_flag_i/dp_result_i come back from it.
module sqrt_ctrl #(
  parameter int DW       = 8,
  parameter int MAX_ITER = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   in_dt_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW/2-1:0] out_root_o,
  output logic            out_err_o,
  output logic            dp_busy_o,
  output logic [DW-1:0]   dp_dt_o,
  input  logic            dp_flag_i,
  input  logic [DW-1:0]   dp_result_i
);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int RW = DW / 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e        state_q, state_d;
  logic [DW-1:0] dt_q, dt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] root_q, root_d;
  logic          err_q, err_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dt_q    <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      err_q   <= err_d;
    end
  end
  // The datapath steps once more on the exit edge; the root is taken from cnt
  // and dp_result_i is compared before that edge, so the extra step is harmless.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        dt_d    = in_dt_i;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: if (dp_flag_i) begin
        if (cnt_q == CW'(MAX_ITER)) begin
          root_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        root_d  = (dt_q == '0) ? '0 : RW'(cnt_q) + RW'(1);
        err_d   = dp_result_i != DW'(cnt_q);
        state_d = DONE;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign dp_busy_o   = state_q == CALC;
  assign dp_dt_o     = dt_q;
  assign out_root_o  = root_q;
  assign out_err_o   = err_q;
endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb_sqrt_ctrl: randomized self-checking bench for sqrt_ctrl with behavioural datapath models
module tb_sqrt_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  logic       v1 = 1'b0, rdy1 = 1'b0, irdy1, ov1, err1, busy1, flag1;
  logic [7:0] dt1 = '0, ddt1, res1, k1;
  logic [3:0] root1;
  logic       v2 = 1'b0, rdy2 = 1'b0, irdy2, ov2, err2, busy2, flag2;
  logic [7:0] dt2 = '0, ddt2, res2, k2;
  logic [3:0] root2;
  logic [7:0] bias = '0;
  int total = 0, bad = 0;
  sqrt_ctrl u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(v1), .in_ready_o(irdy1), .in_dt_i(dt1),
    .out_valid_o(ov1), .out_ready_i(rdy1), .out_root_o(root1), .out_err_o(err1),
    .dp_busy_o(busy1), .dp_dt_o(ddt1), .dp_flag_i(flag1), .dp_result_i(res1)
  );
  sqrt_ctrl #(.DW(8), .MAX_ITER(2)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(v2), .in_ready_o(irdy2), .in_dt_i(dt2),
    .out_valid_o(ov2), .out_ready_i(rdy2), .out_root_o(root2), .out_err_o(err2),
    .dp_busy_o(busy2), .dp_dt_o(ddt2), .dp_flag_i(flag2), .dp_result_i(res2)
  );
  // Odd-sum datapath: iterator k resets while busy is low, steps each busy cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k1 <= '0;
      k2 <= '0;
    end else begin
      k1 <= busy1 ? k1 + 8'd1 : '0;
      k2 <= busy2 ? k2 + 8'd1 : '0;
    end
  end
  always_comb begin
    flag1 = (int'(k1) + 2) * (int'(k1) + 2) <= int'(ddt1);
    flag2 = (int'(k2) + 2) * (int'(k2) + 2) <= int'(ddt2);
    res1  = k1 + bias;
    res2  = k2 + bias;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  task automatic run1(input logic [7:0] dt, input int hold);
    int r, k, lat;
    r = isqrt(int'(dt));
    k = (r == 0) ? 0 : r - 1;
    @(negedge clk_i);
    chk("idle_rdy", int'(irdy1), 1);
    v1 = 1'b1;
    dt1 = dt;
    @(negedge clk_i);
    v1 = 1'b0;
    dt1 = 8'($urandom);
    lat = 0;
    while (!ov1 && lat < 40) begin
      chk("busy", int'(busy1), 1);
      chk("calc_rdy", int'(irdy1), 0);
      chk("dp_dt", int'(ddt1), int'(dt));
      rdy1 = 1'($urandom);
      dt1 = 8'($urandom);
      @(negedge clk_i);
      lat++;
    end
    rdy1 = 1'b0;
    chk("lat", lat, k + 1);
    chk("busy_done", int'(busy1), 0);
    for (int i = 0; i < hold; i++) begin
      chk("root_hold", int'(root1), r);
      chk("err_hold", int'(err1), int'(bias != 0));
      chk("valid_hold", int'(ov1), 1);
      chk("done_rdy", int'(irdy1), 0);
      v1 = 1'b1;
      dt1 = 8'($urandom);
      @(negedge clk_i);
    end
    chk("root", int'(root1), r);
    chk("err", int'(err1), int'(bias != 0));
    rdy1 = 1'b1;
    v1 = 1'b0;
    @(negedge clk_i);
    chk("valid_clr", int'(ov1), 0);
    chk("post_rdy", int'(irdy1), 1);
    rdy1 = 1'b0;
  endtask
  task automatic run2(input logic [7:0] dt);
    int r, k, lat;
    logic ab;
    r = isqrt(int'(dt));
    k = (r == 0) ? 0 : r - 1;
    ab = k > 2;
    @(negedge clk_i);
    v2 = 1'b1;
    dt2 = dt;
    @(negedge clk_i);
    v2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    chk("m2_lat", lat, (ab ? 2 : k) + 1);
    chk("m2_root", int'(root2), ab ? 0 : r);
    chk("m2_err", int'(err2), int'(ab));
    rdy2 = 1'b1;
    @(negedge clk_i);
    chk("m2_valid_clr", int'(ov2), 0);
    rdy2 = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_busy", int'(busy1), 0);
    chk("rst_valid", int'(ov1), 0);
    chk("rst_root", int'(root1), 0);
    chk("rst_err", int'(err1), 0);
    chk("rst_dt", int'(ddt1), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run1(8'd0, 0);
    run1(8'd16, 0);
    run1(8'd15, 0);
    run1(8'd1, 0);
    run1(8'd255, 0);
    run1(8'd100, 10);
    bias = 8'd1;
    run1(8'd49, 2);
    bias = 8'd0;
    run2(8'd100);
    run2(8'd4);
    run2(8'd9);
    run2(8'd16);
    for (int i = 0; i < 20; i++) run1(8'($urandom), int'($urandom_range(0, 3)));
    for (int i = 0; i < 10; i++) run2(8'($urandom));
    run1(8'd200, 0);
    @(negedge clk_i);
    v1 = 1'b1;
    dt1 = 8'd200;
    @(negedge clk_i);
    v1 = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_busy", int'(busy1), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", int'(busy1), 0);
    chk("arst_valid", int'(ov1), 0);
    chk("arst_root", int'(root1), 0);
    chk("arst_err", int'(err1), 0);
    chk("arst_dt", int'(ddt1), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_valid", int'(ov1), 0);
      chk("post_rst_rdy", int'(irdy1), 1);
    end
    run1(8'd9, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
